// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its helpers.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN,
      MEMWAIT,
      DRAIN,
      HALTED
   } hz_state_t;

   typedef struct packed {
      logic en;
      logic flush;
   } stage_ctrl_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   localparam stage_ctrl_t SC_HOLD  = '{en: 1'b0, flush: 1'b0};
   localparam stage_ctrl_t SC_PASS  = '{en: 1'b1, flush: 1'b0};
   localparam stage_ctrl_t SC_SQUASH_IN = '{en: 1'b0, flush: 1'b1};
   // idex needs both en and flush set so the bubble is actually captured
   localparam stage_ctrl_t SC_BUBBLE = '{en: 1'b1, flush: 1'b1};

   function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
      return (dst != REG_ZERO) && (dst == src);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs from the datapath and pipeline-register controls back to it.
interface pipeline_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic             ihit;
   logic             dhit;
   logic             dREN_MEM;
   logic             dWEN_MEM;
   logic             memtoReg_EX;
   logic [4:0]       rt_EX;
   logic [4:0]       rs_ID;
   logic [4:0]       rt_ID;
   logic             redirect_EX;
   logic             halt_EX;

   logic             pc_en;
   logic             ifid_en;
   logic             ifid_flush;
   logic             idex_en;
   logic             idex_flush;
   logic             exmem_en;
   logic             exmem_flush;
   logic             memwb_en;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output ihit, dhit, dREN_MEM, dWEN_MEM, memtoReg_EX,
             rt_EX, rs_ID, rt_ID, redirect_EX, halt_EX,
      input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
             exmem_en, exmem_flush, memwb_en, halted, stall_cnt
   );

   modport slave (
      input  ihit, dhit, dREN_MEM, dWEN_MEM, memtoReg_EX,
             rt_EX, rs_ID, rt_ID, redirect_EX, halt_EX,
      output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
             exmem_en, exmem_flush, memwb_en, halted, stall_cnt
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds ID.
module load_use_detect
   import hazard_pkg::*;
(
   input  logic       memtoReg_EX,
   input  logic [4:0] rt_EX,
   input  logic [4:0] rs_ID,
   input  logic [4:0] rt_ID,
   output logic       load_use
);

   always_comb begin
      load_use = memtoReg_EX &&
                 (reg_match(rt_EX, rs_ID) || reg_match(rt_EX, rt_ID));
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush controller: load-use, redirect, memory wait and halt drain.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = 2,
   parameter int unsigned CNT_W        = 32
) (
   input  logic                   CLK,
   input  logic                   nRST,
   pipeline_hazard_ctrl_if.slave  hz
);

   localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   hz_state_t        state, next_state;
   logic [DW-1:0]    drain_cnt, drain_nxt;
   logic [CNT_W-1:0] stall_cnt_r;

   logic        dwait;
   logic        load_use;
   logic        pc_en;
   logic        halted_o;
   logic        memwb_en;
   stage_ctrl_t ifid, idex, exmem;

   load_use_detect u_load_use (
      .memtoReg_EX (hz.memtoReg_EX),
      .rt_EX       (hz.rt_EX),
      .rs_ID       (hz.rs_ID),
      .rt_ID       (hz.rt_ID),
      .load_use    (load_use)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= RUN;
         drain_cnt <= '0;
      end else begin
         state     <= next_state;
         drain_cnt <= drain_nxt;
      end
   end

   always_comb begin
      next_state = state;
      drain_nxt  = drain_cnt;
      pc_en      = 1'b0;
      ifid       = SC_HOLD;
      idex       = SC_HOLD;
      exmem      = SC_HOLD;
      memwb_en   = 1'b0;
      halted_o   = 1'b0;
      dwait      = (hz.dREN_MEM | hz.dWEN_MEM) & ~hz.dhit;

      if (nRST) begin
         case (state)
            HALTED: begin
               halted_o = 1'b1;
            end

            // a memory wait inside DRAIN freezes without leaving DRAIN
            DRAIN: begin
               if (!dwait) begin
                  ifid     = SC_SQUASH_IN;
                  idex     = SC_BUBBLE;
                  exmem    = SC_PASS;
                  memwb_en = 1'b1;
                  if (drain_cnt <= DW'(1)) begin
                     next_state = HALTED;
                     drain_nxt  = '0;
                  end else begin
                     drain_nxt = drain_cnt - DW'(1);
                  end
               end
            end

            default: begin
               if (dwait) begin
                  next_state = MEMWAIT;
               end else begin
                  next_state = RUN;
                  exmem      = SC_PASS;
                  memwb_en   = 1'b1;
                  // the halt cycle itself counts as the first drain cycle
                  if (hz.halt_EX) begin
                     ifid = SC_SQUASH_IN;
                     idex = SC_BUBBLE;
                     if (DRAIN_CYCLES <= 1) begin
                        next_state = HALTED;
                     end else begin
                        next_state = DRAIN;
                        drain_nxt  = DW'(DRAIN_CYCLES - 1);
                     end
                  end else if (hz.redirect_EX) begin
                     pc_en = 1'b1;
                     ifid  = SC_SQUASH_IN;
                     idex  = SC_BUBBLE;
                  end else if (load_use || !hz.ihit) begin
                     ifid = SC_HOLD;
                     idex = SC_BUBBLE;
                  end else begin
                     pc_en = 1'b1;
                     ifid  = SC_PASS;
                     idex  = SC_PASS;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt_r <= '0;
      end else if (!pc_en && (state != HALTED) && (stall_cnt_r != '1)) begin
         stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
   end

   assign hz.pc_en       = pc_en;
   assign hz.ifid_en     = ifid.en;
   assign hz.ifid_flush  = ifid.flush;
   assign hz.idex_en     = idex.en;
   assign hz.idex_flush  = idex.flush;
   assign hz.exmem_en    = exmem.en;
   assign hz.exmem_flush = exmem.flush;
   assign hz.memwb_en    = memwb_en;
   assign hz.halted      = halted_o;
   assign hz.stall_cnt   = stall_cnt_r;

endmodule
